// File: rtl/obi_axi_lite_bridge.sv
// OBI slave to AXI4-Lite master bridge with configurable outstanding depth.
// One issue-stage register feeds AW/W/AR; an order FIFO keeps OBI responses in request order.
module obi_axi_lite_bridge #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxTrans  = 4,
    parameter logic [2:0]  AxiProt   = 3'b000,
    localparam int unsigned StrbWidth = DataWidth / 8,
    localparam int unsigned CntWidth  = $clog2(MaxTrans + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 obi_req_i,
    output logic                 obi_gnt_o,
    input  logic [AddrWidth-1:0] obi_addr_i,
    input  logic                 obi_we_i,
    input  logic [StrbWidth-1:0] obi_be_i,
    input  logic [DataWidth-1:0] obi_wdata_i,
    output logic                 obi_rvalid_o,
    output logic [DataWidth-1:0] obi_rdata_o,
    output logic                 obi_err_o,

    output logic                 aw_valid_o,
    input  logic                 aw_ready_i,
    output logic [AddrWidth-1:0] aw_addr_o,
    output logic [2:0]           aw_prot_o,

    output logic                 w_valid_o,
    input  logic                 w_ready_i,
    output logic [DataWidth-1:0] w_data_o,
    output logic [StrbWidth-1:0] w_strb_o,

    input  logic                 b_valid_i,
    output logic                 b_ready_o,
    input  logic [1:0]           b_resp_i,

    output logic                 ar_valid_o,
    input  logic                 ar_ready_i,
    output logic [AddrWidth-1:0] ar_addr_o,
    output logic [2:0]           ar_prot_o,

    input  logic                 r_valid_i,
    output logic                 r_ready_o,
    input  logic [DataWidth-1:0] r_data_i,
    input  logic [1:0]           r_resp_i,

    output logic [CntWidth-1:0]  outstanding_o,
    output logic                 busy_o
);

    localparam int unsigned PtrWidth = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(MaxTrans);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(MaxTrans - 1);

    logic                 aw_p;
    logic                 w_p;
    logic                 ar_p;
    logic [AddrWidth-1:0] st_addr;
    logic [StrbWidth-1:0] st_be;
    logic [DataWidth-1:0] st_wdata;

    logic [MaxTrans-1:0]  order_q;
    logic [PtrWidth-1:0]  wr_ptr;
    logic [PtrWidth-1:0]  rd_ptr;
    logic [CntWidth-1:0]  count;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic b_hs;
    logic r_hs;
    logic b_rdy;
    logic r_rdy;
    logic stage_free;
    logic grant;
    logic fifo_empty;
    logic head_we;
    logic pop;
    logic unused_resp_lsb;

    function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        aw_hs      = aw_p & aw_ready_i;
        w_hs       = w_p & w_ready_i;
        ar_hs      = ar_p & ar_ready_i;
        // The stage can reload in the same cycle its last pending channel handshakes.
        stage_free = (!aw_p || aw_ready_i) && (!w_p || w_ready_i) && (!ar_p || ar_ready_i);
        grant      = obi_req_i && !rst_i && (count < MaxCnt) && stage_free;
        fifo_empty = (count == '0);
        head_we    = order_q[rd_ptr];
        b_rdy      = !fifo_empty && head_we;
        r_rdy      = !fifo_empty && !head_we;
        b_hs       = b_valid_i && b_rdy;
        r_hs       = r_valid_i && r_rdy;
        pop        = b_hs || r_hs;
    end

    assign unused_resp_lsb = b_resp_i[0] ^ r_resp_i[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_p     <= 1'b0;
            w_p      <= 1'b0;
            ar_p     <= 1'b0;
            st_addr  <= '0;
            st_be    <= '0;
            st_wdata <= '0;
        end else if (grant) begin
            aw_p     <= obi_we_i;
            w_p      <= obi_we_i;
            ar_p     <= !obi_we_i;
            st_addr  <= obi_addr_i;
            st_be    <= obi_be_i;
            st_wdata <= obi_we_i ? obi_wdata_i : '0;
        end else begin
            if (aw_hs) aw_p <= 1'b0;
            if (w_hs)  w_p  <= 1'b0;
            if (ar_hs) ar_p <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            order_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (grant) begin
                order_q[wr_ptr] <= obi_we_i;
                wr_ptr          <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({grant, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            obi_rvalid_o <= 1'b0;
            obi_rdata_o  <= '0;
            obi_err_o    <= 1'b0;
        end else begin
            obi_rvalid_o <= pop;
            if (r_hs) begin
                obi_rdata_o <= r_data_i;
                obi_err_o   <= r_resp_i[1];
            end else if (b_hs) begin
                obi_rdata_o <= '0;
                obi_err_o   <= b_resp_i[1];
            end else begin
                obi_rdata_o <= '0;
                obi_err_o   <= 1'b0;
            end
        end
    end

    assign obi_gnt_o     = grant;
    assign aw_valid_o    = aw_p;
    assign aw_addr_o     = st_addr;
    assign aw_prot_o     = AxiProt;
    assign w_valid_o     = w_p;
    assign w_data_o      = st_wdata;
    assign w_strb_o      = st_be;
    assign ar_valid_o    = ar_p;
    assign ar_addr_o     = st_addr;
    assign ar_prot_o     = AxiProt;
    assign b_ready_o     = b_rdy;
    assign r_ready_o     = r_rdy;
    assign outstanding_o = count;
    assign busy_o        = (count != '0) || aw_p || w_p || ar_p;

endmodule

// File: tb/tb_obi_axi_lite_bridge.sv
// Scoreboard bench for obi_axi_lite_bridge: randomized OBI traffic against a modelled AXI-Lite slave.
module tb_obi_axi_lite_bridge;

    localparam int unsigned MT = 4;
    localparam int unsigned CW = $clog2(MT + 1);

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        obi_req_i = 1'b0;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i = '0;
    logic        obi_we_i = 1'b0;
    logic [3:0]  obi_be_i = '0;
    logic [31:0] obi_wdata_i = '0;
    logic        obi_rvalid_o;
    logic [31:0] obi_rdata_o;
    logic        obi_err_o;
    logic        aw_valid_o, aw_ready_i = 1'b0;
    logic [31:0] aw_addr_o;
    logic [2:0]  aw_prot_o;
    logic        w_valid_o, w_ready_i = 1'b0;
    logic [31:0] w_data_o;
    logic [3:0]  w_strb_o;
    logic        b_valid_i = 1'b0, b_ready_o;
    logic [1:0]  b_resp_i = '0;
    logic        ar_valid_o, ar_ready_i = 1'b0;
    logic [31:0] ar_addr_o;
    logic [2:0]  ar_prot_o;
    logic        r_valid_i = 1'b0, r_ready_o;
    logic [31:0] r_data_i = '0;
    logic [1:0]  r_resp_i = '0;
    logic [CW-1:0] outstanding_o;
    logic        busy_o;

    obi_axi_lite_bridge #(
        .AddrWidth(32),
        .DataWidth(32),
        .MaxTrans (MT),
        .AxiProt  (3'b000)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
        .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
        .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_prot_o(aw_prot_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_prot_o(ar_prot_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
        .outstanding_o(outstanding_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Expected OBI responses {rdata, err} in request order, and expected AW/W payloads.
    logic [32:0] exp_q[$];
    logic [31:0] exp_aw[$];
    logic [35:0] exp_w[$];

    // Slave-side state: knobs are percent probabilities of ready/valid per cycle.
    int aw_pct = 100, w_pct = 100, ar_pct = 100, b_pct = 100, r_pct = 100;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    logic [31:0] aw_pend[$];
    int w_cnt = 0;
    bit mark_r = 0;
    int r_first_hs = -1;
    int g_cyc[6];
    bit depth_done;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0], ~a[31:16]} ^ 32'h13579BDF;
    endfunction

    function automatic logic [1:0] resp_of(input logic [31:0] a);
        return a[9:8];
    endfunction

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d, output int gcyc);
        bit done;
        done = 0;
        gcyc = -1;
        obi_req_i = 1'b1; obi_we_i = we; obi_addr_i = a; obi_be_i = be; obi_wdata_i = d;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk_i);
            if (obi_gnt_o) begin
                done = 1;
                gcyc = cyc + 1;
                exp_q.push_back(we ? {32'h0, resp_of(a)[1]} : {data_of(a), resp_of(a)[1]});
                if (we) begin
                    exp_aw.push_back(a);
                    exp_w.push_back({be, d});
                end
            end
            @(posedge clk_i); #1;
        end
        obi_req_i = 1'b0;
        if (!done) chk("grant_timeout", 0, 1);
        else if (we) chk("aw_w_valid_after_gnt", {aw_valid_o, w_valid_o}, 2'b11);
        else chk("ar_valid_after_gnt", ar_valid_o, 1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk_i);
            if (exp_q.size() == 0 && exp_aw.size() == 0 && exp_w.size() == 0) done = 1;
        end
        if (!done) chk("drain_timeout", 0, 1);
        @(negedge clk_i);
        chk("drain_outstanding", outstanding_o, 0);
        chk("drain_busy", busy_o, 0);
        @(posedge clk_i); #1;
    endtask

    // AXI-Lite slave model plus OBI response monitor.
    initial begin
        logic rv_exp;
        logic bh, rh;
        logic [32:0] e;
        logic [35:0] ew;
        logic [31:0] ea;
        logic [33:0] rr;
        rv_exp = 0; bh = 0; rh = 0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                exp_q.delete(); exp_aw.delete(); exp_w.delete();
                bq.delete(); rq.delete(); aw_pend.delete();
                w_cnt = 0; rv_exp = 0; bh = 0; rh = 0;
            end else begin
                chk("rvalid_timing", obi_rvalid_o, rv_exp);
                if (obi_rvalid_o) begin
                    if (exp_q.size() == 0) chk("unexpected_rvalid", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("rdata", obi_rdata_o, e[32:1]);
                        chk("err", obi_err_o, e[0]);
                    end
                end
                if (aw_valid_o && aw_ready_i) begin
                    chk("aw_prot", aw_prot_o, 0);
                    if (exp_aw.size() == 0) chk("unexpected_aw", 1, 0);
                    else begin
                        ea = exp_aw.pop_front();
                        chk("aw_addr", aw_addr_o, ea);
                    end
                    aw_pend.push_back(aw_addr_o);
                end
                if (w_valid_o && w_ready_i) begin
                    if (exp_w.size() == 0) chk("unexpected_w", 1, 0);
                    else begin
                        ew = exp_w.pop_front();
                        chk("w_strb_data", {w_strb_o, w_data_o}, ew);
                    end
                    w_cnt++;
                end
                while (aw_pend.size() > 0 && w_cnt > 0) begin
                    ea = aw_pend.pop_front();
                    bq.push_back(resp_of(ea));
                    w_cnt--;
                end
                if (ar_valid_o && ar_ready_i) begin
                    chk("ar_prot", ar_prot_o, 0);
                    rq.push_back({data_of(ar_addr_o), resp_of(ar_addr_o)});
                end
                bh = b_valid_i && b_ready_o;
                rh = r_valid_i && r_ready_o;
                if (bh) void'(bq.pop_front());
                if (rh) begin
                    void'(rq.pop_front());
                    if (mark_r && r_first_hs < 0) r_first_hs = cyc + 1;
                end
                rv_exp = bh || rh;
            end
            @(posedge clk_i); #1;
            if (rst_i) begin
                aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
                b_valid_i = 0; b_resp_i = 0; r_valid_i = 0; r_data_i = 0; r_resp_i = 0;
            end else begin
                aw_ready_i = pct(aw_pct);
                w_ready_i  = pct(w_pct);
                ar_ready_i = pct(ar_pct);
                if (!(b_valid_i && !bh)) begin
                    if (bq.size() > 0 && pct(b_pct)) begin
                        b_valid_i = 1; b_resp_i = bq[0];
                    end else begin
                        b_valid_i = 0; b_resp_i = 0;
                    end
                end
                if (!(r_valid_i && !rh)) begin
                    if (rq.size() > 0 && pct(r_pct)) begin
                        rr = rq[0];
                        r_valid_i = 1; r_data_i = rr[33:2]; r_resp_i = rr[1:0];
                    end else begin
                        r_valid_i = 0; r_data_i = 0; r_resp_i = 0;
                    end
                end
            end
        end
    end

    initial begin
        int g;
        int granted;
        bit ok;
        #1 rst_i = 1'b1;
        #2;
        chk("reset_ctrl", {obi_gnt_o, obi_rvalid_o, obi_err_o, aw_valid_o, w_valid_o, ar_valid_o,
                           b_ready_o, r_ready_o, busy_o, outstanding_o}, 0);
        repeat (3) @(posedge clk_i);
        #3 rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Single read with DEADBEEF data
        issue(1'b0, 32'h100, 4'hF, 32'h0, g);
        drain();

        // Write where W is accepted before AW
        aw_pct = 0;
        issue(1'b1, 32'h20, 4'b0110, 32'h11223344, g);
        repeat (3) @(negedge clk_i);
        chk("w_before_aw", {aw_valid_o, w_valid_o}, 2'b10);
        aw_pct = 100;
        @(posedge clk_i); #1;
        drain();

        // Ordering: R offered before B must stall
        b_pct = 0;
        issue(1'b1, 32'h40, 4'hF, 32'hCAFEF00D, g);
        issue(1'b0, 32'h44, 4'hF, 32'h0, g);
        repeat (6) @(negedge clk_i);
        chk("r_stalled_behind_b", {r_valid_i, r_ready_o, b_ready_o}, 3'b101);
        b_pct = 100;
        @(posedge clk_i); #1;
        drain();

        // Depth: six back-to-back reads with R held off
        r_pct = 0;
        depth_done = 0;
        for (int i = 0; i < 6; i++) g_cyc[i] = -1;
        fork
            begin
                int gg;
                for (int i = 0; i < 6; i++) begin
                    issue(1'b0, 32'h1000 + 32'(i * 4), 4'hF, 32'h0, gg);
                    g_cyc[i] = gg;
                end
                depth_done = 1;
            end
        join_none
        repeat (20) @(negedge clk_i);
        granted = 0;
        for (int i = 0; i < 6; i++) if (g_cyc[i] >= 0) granted++;
        chk("depth_grants", granted, 4);
        chk("depth_outstanding", outstanding_o, 4);
        chk("depth_gnt_low", {obi_req_i, obi_gnt_o}, 2'b10);
        mark_r = 1;
        r_pct = 100;
        ok = 0;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge clk_i);
            if (depth_done) ok = 1;
        end
        if (!ok) chk("depth_timeout", 0, 1);
        chk("fifth_grant_after_pop", g_cyc[4], r_first_hs + 1);
        mark_r = 0;
        @(posedge clk_i); #1;
        drain();

        // Error responses on read (SLVERR) and write (DECERR)
        issue(1'b0, 32'h200, 4'hF, 32'h0, g);
        issue(1'b1, 32'h300, 4'hF, 32'h55AA55AA, g);
        drain();

        // Reset with three reads outstanding
        r_pct = 0;
        for (int i = 0; i < 3; i++) issue(1'b0, 32'h2000 + 32'(i * 4), 4'hF, 32'h0, g);
        repeat (3) @(posedge clk_i);
        #1 chk("pre_reset_outstanding", outstanding_o, 3);
        #2 rst_i = 1'b1;
        #1;
        chk("reset_ctrl_mid", {obi_gnt_o, obi_rvalid_o, obi_err_o, aw_valid_o, w_valid_o, ar_valid_o,
                               b_ready_o, r_ready_o, busy_o, outstanding_o}, 0);
        chk("reset_addr", {aw_addr_o, ar_addr_o}, 0);
        chk("reset_data", {w_strb_o, w_data_o, obi_rdata_o[27:0]}, 0);
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b0;
        r_pct = 100;
        repeat (10) @(negedge clk_i);
        chk("no_resp_after_reset", outstanding_o, 0);
        @(posedge clk_i); #1;
        issue(1'b0, 32'h104, 4'hF, 32'h0, g);
        drain();

        // Randomized mixed traffic
        for (int ph = 0; ph < 4; ph++) begin
            aw_pct = $urandom_range(30, 100);
            w_pct  = $urandom_range(30, 100);
            ar_pct = $urandom_range(30, 100);
            b_pct  = $urandom_range(30, 100);
            r_pct  = $urandom_range(30, 100);
            for (int n = 0; n < 40; n++) begin
                logic [31:0] a;
                logic [31:0] d;
                logic [3:0]  be;
                a = $urandom; d = $urandom; be = 4'($urandom);
                issue(1'($urandom), a, be, d, g);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk_i); #1;
                end
            end
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
